// File: rtl/mux2_arbiter_pkg.sv
// Shared definitions for the two-requester mux arbiter: state encodings and
// default sizing.
package mux2_arb_defs;

    // Grant FSM encoding; 2'b11 is unused and falls back to idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } arb_state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/mux_chip_2to1.sv
// One-bit 2:1 mux cell; the arbiter instantiates one per data bit.
module mux_chip_2to1 (
    output logic out,
    input  logic a,
    input  logic b,
    input  logic s
);

    assign out = s ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter that owns the select of a shared WIDTH-bit 2:1 mux.
// A tenure is capped at MAX_HOLD cycles only while the other side is
// waiting; an uncontended owner keeps the datapath indefinitely.
module mux2_arbiter
    import mux2_arb_defs::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             grant0,
    output logic             grant1,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state;
    arb_state_t        next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              last;
    logic              at_limit;
    logic              entering;

    assign at_limit = (hold_cnt == HOLD_LAST);

    // Next-state decision: lone requests win outright, ties go to whoever
    // did not own the datapath last, and a contended owner is rotated out
    // once its counter reaches the limit.
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (req0 && req1)
                    next_state = last ? ST_G0 : ST_G1;
                else if (req0)
                    next_state = ST_G0;
                else if (req1)
                    next_state = ST_G1;
                else
                    next_state = ST_IDLE;
            end
            ST_G0: begin
                if (!req0)
                    next_state = req1 ? ST_G1 : ST_IDLE;
                else if (req1 && at_limit)
                    next_state = ST_G1;
                else
                    next_state = ST_G0;
            end
            ST_G1: begin
                if (!req1)
                    next_state = req0 ? ST_G0 : ST_IDLE;
                else if (req0 && at_limit)
                    next_state = ST_G0;
                else
                    next_state = ST_G1;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // A fresh tenure starts whenever we move into a grant state from
    // anywhere else, including a direct G0<->G1 handover.
    assign entering = (next_state != state) &&
                      ((next_state == ST_G0) || (next_state == ST_G1));

    // State, registered grants/select, round-robin memory and hold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant0   <= 1'b0;
            grant1   <= 1'b0;
            sel      <= 1'b0;
            last     <= 1'b1;
            hold_cnt <= '0;
        end else begin
            state  <= next_state;
            grant0 <= (next_state == ST_G0);
            grant1 <= (next_state == ST_G1);
            sel    <= (next_state == ST_G1);
            if (entering) begin
                last     <= (next_state == ST_G1);
                hold_cnt <= '0;
            end else if (((state == ST_G0) || (state == ST_G1)) && !at_limit) begin
                // Saturate rather than wrap so a long uncontended tenure
                // still yields promptly once the other side asks.
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign out_valid = grant0 | grant1;

    // Bit-sliced datapath, all slices steered by the registered select.
    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux_chip_2to1 u_mux (
            .out (out[i]),
            .a   (data0[i]),
            .b   (data1[i]),
            .s   (sel)
        );
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: reset, lone request, contention rotation,
// early release, round-robin memory, saturation and async reset.
module tb_mux2_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0, req1;
    logic [WIDTH-1:0] data0, data1;
    logic             grant0, grant1, sel, out_valid;
    logic [WIDTH-1:0] out;

    int tests = 0;
    int fails = 0;

    mux2_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .grant0    (grant0),
        .grant1    (grant1),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
        data0 = 8'h3C; data1 = 8'hC3;
        step(); step();
        tests++;
        if ({grant0, grant1, sel, out_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outputs: got g0g1 sel v=%b required 0000",
                     {grant0, grant1, sel, out_valid});
        end
        reset = 1'b0;
        step();
        tests++;
        if ({grant0, grant1, sel, out} !== {3'b100, 8'h3C}) begin
            fails++;
            $display("FAIL reset_first_grant: got g0=%b g1=%b sel=%b out=%h required 1 0 0 3c",
                     grant0, grant1, sel, out);
        end
    endtask

    task automatic test_lone_request();
        do_reset();
        data0 = 8'h00; data1 = 8'hA5;
        req1 = 1'b1;
        step();
        tests++;
        if ({grant0, grant1, sel, out_valid, out} !== {4'b0111, 8'hA5}) begin
            fails++;
            $display("FAIL lone_grant: got g0=%b g1=%b sel=%b v=%b out=%h required 0 1 1 1 a5",
                     grant0, grant1, sel, out_valid, out);
        end
        req1 = 1'b0;
        step();
        tests++;
        if ({grant0, grant1, out_valid} !== 3'b000) begin
            fails++;
            $display("FAIL lone_release: got g0=%b g1=%b v=%b required 0 0 0",
                     grant0, grant1, out_valid);
        end
    endtask

    task automatic test_contention();
        logic exp0;
        do_reset();
        data0 = 8'h11; data1 = 8'h22;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            exp0 = (((k / MAX_HOLD) % 2) == 0);
            tests++;
            if ({grant0, grant1, out} !== {exp0, ~exp0, exp0 ? 8'h11 : 8'h22}) begin
                fails++;
                $display("FAIL contention_cycle%0d: got g0=%b g1=%b out=%h required %b %b %h",
                         k, grant0, grant1, out, exp0, ~exp0, exp0 ? 8'h11 : 8'h22);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_early_release();
        do_reset();
        data0 = 8'h5A; data1 = 8'h6B;
        req0 = 1'b1; req1 = 1'b1;
        step();
        step();
        tests++;
        if ({grant0, grant1} !== 2'b10) begin
            fails++;
            $display("FAIL early_hold: got g0=%b g1=%b required 1 0", grant0, grant1);
        end
        req0 = 1'b0;
        step();
        tests++;
        if ({grant0, grant1, sel, out_valid, out} !== {4'b0111, 8'h6B}) begin
            fails++;
            $display("FAIL early_handover: got g0=%b g1=%b sel=%b v=%b out=%h required 0 1 1 1 6b",
                     grant0, grant1, sel, out_valid, out);
        end
        req1 = 1'b0;
        step();
    endtask

    task automatic test_round_robin_memory();
        do_reset();
        req0 = 1'b1; step();
        req0 = 1'b0; req1 = 1'b1; step();
        req1 = 1'b0; step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rr_idle: got v=%b required 0", out_valid);
        end
        req0 = 1'b1; req1 = 1'b1; step();
        tests++;
        if ({grant0, grant1} !== 2'b10) begin
            fails++;
            $display("FAIL rr_after_g1: got g0=%b g1=%b required 1 0", grant0, grant1);
        end
        req0 = 1'b0; req1 = 1'b0; step();
        req0 = 1'b1; req1 = 1'b1; step();
        tests++;
        if ({grant0, grant1} !== 2'b01) begin
            fails++;
            $display("FAIL rr_after_g0: got g0=%b g1=%b required 0 1", grant0, grant1);
        end
        req0 = 1'b0; req1 = 1'b0; step();
    endtask

    task automatic test_saturation();
        do_reset();
        req0 = 1'b1;
        for (int k = 0; k < 10; k++) step();
        tests++;
        if ({grant0, grant1} !== 2'b10) begin
            fails++;
            $display("FAIL sat_tenure: got g0=%b g1=%b required 1 0", grant0, grant1);
        end
        req1 = 1'b1;
        step();
        tests++;
        if ({grant0, grant1} !== 2'b01) begin
            fails++;
            $display("FAIL sat_yield: got g0=%b g1=%b required 0 1", grant0, grant1);
        end
        req0 = 1'b0; req1 = 1'b0; step();
    endtask

    task automatic test_async_reset();
        do_reset();
        req1 = 1'b1;
        step();
        tests++;
        if (grant1 !== 1'b1) begin
            fails++;
            $display("FAIL async_pre: got g1=%b required 1", grant1);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({grant1, sel, out_valid} !== 3'b000) begin
            fails++;
            $display("FAIL async_drop: got g1=%b sel=%b v=%b required 0 0 0",
                     grant1, sel, out_valid);
        end
        step();
        reset = 1'b0;
        req1 = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        data0 = '0; data1 = '0;
        test_reset();
        test_lone_request();
        test_contention();
        test_early_release();
        test_round_robin_memory();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
